// File: rtl/irq_capture.sv
// irq_capture
//   Conditions raw push-button lines into clean, latched interrupt requests.
//   Each line passes through an optional inversion and a two-flop synchroniser,
//   then a debouncer. A debounced 0->1 transition ("accept") sets that channel's
//   pending bit, which is held until the interrupt controller grants the channel.
//
// Ports
//   clk         system clock
//   in_RST      synchronous active-low reset
//   btn_raw     raw, asynchronous button levels
//   irq_ack     grant vector from the interrupt controller; bit i clears pending i
//   lost_clr    clears all irq_lost bits
//   irq_pend    latched pending requests
//   irq_lost    sticky: a channel was accepted again while still pending
//   irq_stable  debounced levels
//   irq_cnt     accepted-request count, wraps modulo 2^CNT_W
module irq_capture #(
  parameter int NCH             = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             in_RST,
  input  logic [NCH-1:0]   btn_raw,
  input  logic [NCH-1:0]   irq_ack,
  input  logic             lost_clr,
  output logic [NCH-1:0]   irq_pend,
  output logic [NCH-1:0]   irq_lost,
  output logic [NCH-1:0]   irq_stable,
  output logic [CNT_W-1:0] irq_cnt
);

  localparam int             DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] TERM    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic           LVL_INV = (BTN_ACTIVE_LOW != 0);

  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s2;
  logic [DCW-1:0]   r_dcnt [NCH];

  logic [NCH-1:0]   w_lvl;
  logic [NCH-1:0]   w_diff;
  logic [NCH-1:0]   w_term;
  logic [NCH-1:0]   w_flip;
  logic [NCH-1:0]   w_acc;
  logic [CNT_W-1:0] w_acc_sum;

  assign w_lvl = btn_raw ^ {NCH{LVL_INV}};

  always_comb begin
    w_term    = '0;
    w_acc_sum = '0;
    w_diff    = r_s2 ^ irq_stable;
    for (int i = 0; i < NCH; i++) begin
      w_term[i] = (r_dcnt[i] == TERM);
    end
    // A flip happens once the synchronised level has disagreed with the
    // stable level for DEBOUNCE_CYCLES consecutive cycles; only rising
    // flips raise a request.
    w_flip = w_diff & w_term;
    w_acc  = w_flip & r_s2;
    for (int i = 0; i < NCH; i++) begin
      w_acc_sum = w_acc_sum + CNT_W'(w_acc[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!in_RST) begin
      r_s1       <= '0;
      r_s2       <= '0;
      irq_stable <= '0;
      irq_pend   <= '0;
      irq_lost   <= '0;
      irq_cnt    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_lvl;
      r_s2 <= r_s1;
      for (int i = 0; i < NCH; i++) begin
        // Any cycle agreeing with the stable level restarts the count.
        if (!w_diff[i] || w_term[i]) begin
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DCW'(1);
        end
      end
      irq_stable <= irq_stable ^ w_flip;
      // A new accept beats a coincident grant on the same channel.
      irq_pend   <= w_acc | (irq_pend & ~irq_ack);
      // Setting beats a coincident clear so no overrun is ever missed.
      irq_lost   <= (w_acc & irq_pend & ~irq_ack) | (irq_lost & ~{NCH{lost_clr}});
      irq_cnt    <= irq_cnt + w_acc_sum;
    end
  end

endmodule
